vga_text_console: RTL and testbench

Character-stream console engine for the VGA text buffer. CPU stores to the console data register push bytes into a small FIFO. The engine then decodes them into character-RAM writes and cursor moves: printable output, CR, LF, BS and form-feed clear. It also arbitrates the single character-RAM port between this engine and direct CPU cell accesses, with the CPU always given priority. It sits between the memory-mapped IO decoder and the dual-port character RAM (CPU side).

---
 rtl/vga_text_console_pkg.sv | 18 +
 rtl/vga_text_console_sync_fifo.sv | 44 ++++
 rtl/vga_text_console.sv | 163 ++++++++++++++++
 tb/tb_vga_text_console.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_text_console_pkg.sv
// Shared constants and types for the VGA text console engine.
package console_pkg;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam int DEF_COLS = 80;
    localparam int DEF_ROWS = 30;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

endpackage

// File: rtl/vga_text_console_sync_fifo.sv
// Registered FIFO with wrap-bit pointers; push-when-full and pop-when-empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/vga_text_console.sv
// Console byte engine: decodes the FIFO stream into character-RAM writes and
// cursor moves, sharing the RAM port with direct CPU accesses (CPU wins).
//   state | meaning
//   IDLE  | decode FIFO head, one byte per cycle
//   CLEAR | fill every cell with a space, stalled by CPU accesses
module vga_text_console
    import console_pkg::*;
#(
    parameter int COLS       = DEF_COLS,
    parameter int ROWS       = DEF_ROWS,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        con_valid,
    input  logic [7:0]  con_data,
    output logic        con_ready,
    output logic        ram_we,
    output logic        ram_re,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic [11:0] cursor,
    output logic        busy
);
    localparam logic [11:0] COLS_W    = 12'(COLS);
    localparam logic [11:0] COLS_M1   = 12'(COLS - 1);
    localparam logic [11:0] ROWS_M1   = 12'(ROWS - 1);
    localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);

    state_t      state, state_n;
    logic [11:0] row, row_n, col, col_n, row_base, rb_n, clr_addr, clr_n, cursor_q;
    logic        full, empty, pop, nl;
    logic [7:0]  head;
    logic        cpu_act, eng_we;
    logic [11:0] eng_addr;
    logic [7:0]  eng_wdata;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (con_valid),
        .din   (con_data),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign cpu_act   = cpu_we | cpu_re;
    assign con_ready = !full;
    assign cursor    = cursor_q;
    assign busy      = !empty || (state != IDLE);

    always_comb begin
        pop       = 1'b0;
        nl        = 1'b0;
        eng_we    = 1'b0;
        eng_addr  = '0;
        eng_wdata = '0;
        state_n   = state;
        row_n     = row;
        col_n     = col;
        rb_n      = row_base;
        clr_n     = clr_addr;
        if (!reset) begin
            if (state == IDLE) begin
                if (!empty) begin
                    if (head >= 8'h20 && head <= 8'h7E) begin
                        if (!cpu_act) begin
                            eng_we    = 1'b1;
                            eng_addr  = cursor_q;
                            eng_wdata = head;
                            pop       = 1'b1;
                            if (col == COLS_M1) nl = 1'b1;
                            else col_n = col + 12'd1;
                        end
                    end else begin
                        pop = 1'b1;
                        case (head)
                            CH_LF: nl = 1'b1;
                            CH_CR: col_n = '0;
                            CH_BS: begin
                                if (col != '0) begin
                                    col_n = col - 12'd1;
                                end else if (row != '0) begin
                                    col_n = COLS_M1;
                                    row_n = row - 12'd1;
                                    rb_n  = row_base - COLS_W;
                                end
                            end
                            CH_FF: begin
                                clr_n   = '0;
                                state_n = CLEAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end else if (!cpu_act) begin
                eng_we    = 1'b1;
                eng_addr  = clr_addr;
                eng_wdata = CH_SPACE;
                if (clr_addr == LAST_CELL) begin
                    clr_n   = '0;
                    row_n   = '0;
                    col_n   = '0;
                    rb_n    = '0;
                    state_n = IDLE;
                end else begin
                    clr_n = clr_addr + 12'd1;
                end
            end
            // Wrapping line feed shared by LF and printable overflow; no scrolling.
            if (nl) begin
                col_n = '0;
                if (row == ROWS_M1) begin
                    row_n = '0;
                    rb_n  = '0;
                end else begin
                    row_n = row + 12'd1;
                    rb_n  = row_base + COLS_W;
                end
            end
        end
    end

    always_comb begin
        if (cpu_act) begin
            ram_we    = cpu_we;
            ram_re    = cpu_re;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else begin
            ram_we    = eng_we;
            ram_re    = 1'b0;
            ram_addr  = eng_addr;
            ram_wdata = eng_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            row_base <= '0;
            clr_addr <= '0;
            cursor_q <= '0;
        end else begin
            state    <= state_n;
            row      <= row_n;
            col      <= col_n;
            row_base <= rb_n;
            clr_addr <= clr_n;
            cursor_q <= rb_n + col_n;
        end
    end

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console with a write scoreboard and a cursor model.
module tb_vga_text_console;
    import console_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we, cpu_re;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready, ram_we, ram_re, busy;
    logic [11:0] ram_addr, cursor;
    logic [7:0]  ram_wdata;

    vga_text_console #(.COLS(80), .ROWS(30), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .con_valid (con_valid),
        .con_data  (con_data),
        .con_ready (con_ready),
        .ram_we    (ram_we),
        .ram_re    (ram_re),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cursor    (cursor),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t expq[$];
    int  wcyc[$];
    int  total  = 0;
    int  bad    = 0;
    int  cyc_no = 0;
    int  mcur   = 0;
    int  r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        wr_t e;
        if (ram_we && !(cpu_we || cpu_re)) begin
            wcyc.push_back(cyc_no);
            if (expq.size() == 0) begin
                chk("sb_unexpected_write", 32'(expq.size()), 32'd1);
            end else begin
                e = expq.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(e.a));
                chk("wr_data", 32'(ram_wdata), 32'(e.d));
            end
        end
    endtask

    task automatic cyc();
        #2;
        monitor();
        @(negedge clk);
        cyc_no++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            expq.push_back({12'(mcur), b});
            mcur = (mcur + 1) % 2400;
        end else if (b == CH_LF) begin
            mcur = ((mcur / 80 + 1) % 30) * 80;
        end else if (b == CH_CR) begin
            mcur = (mcur / 80) * 80;
        end else if (b == CH_BS) begin
            if (mcur > 0) mcur = mcur - 1;
        end else if (b == CH_FF) begin
            for (int i = 0; i < 2400; i++) expq.push_back({12'(i), CH_SPACE});
            mcur = 0;
        end
    endtask

    task automatic push(input logic [7:0] b);
        con_valid = 1'b1;
        con_data  = b;
        model_byte(b);
        cyc();
        con_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            cyc();
            n++;
        end
        #1;
        chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        con_valid = 1'b0; con_data = '0;
        @(negedge clk);
        cyc(); cyc();
        reset = 1'b0;
        #1;
        chk("rst_ready",  32'(con_ready), 32'd1);
        chk("rst_cursor", 32'(cursor),    32'd0);
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_we",     32'(ram_we),    32'd0);
        chk("rst_re",     32'(ram_re),    32'd0);
        chk("rst_addr",   32'(ram_addr),  32'd0);
        chk("rst_wdata",  32'(ram_wdata), 32'd0);

        // "AB" back to back
        wcyc.delete();
        r = cyc_no;
        push(8'h41);
        push(8'h42);
        cyc();
        #1;
        chk("ab_cursor", 32'(cursor), 32'd2);
        chk("ab_busy",   32'(busy),   32'd0);
        chk("ab_nwr",    32'(wcyc.size()), 32'd2);
        if (wcyc.size() == 2) begin
            chk("ab_cyc0", 32'(wcyc[0]), 32'(r + 1));
            chk("ab_cyc1", 32'(wcyc[1]), 32'(r + 2));
        end

        // end-of-row wrap, LF, and LF wrap from the last row
        for (int i = 0; mcur != 79 && i < 200; i++) push(8'h61 + 8'(i % 26));
        push(8'h58);
        drain(20);
        chk("x_cursor", 32'(cursor), 32'd80);
        push(CH_LF);
        drain(20);
        chk("lf_cursor", 32'(cursor), 32'd160);
        for (int i = 0; i < 27; i++) push(CH_LF);
        drain(20);
        chk("row29_cursor", 32'(cursor), 32'd2320);
        push(CH_LF);
        drain(20);
        chk("lf_wrap_cursor", 32'(cursor), 32'd0);

        // form-feed clear with a 5-cycle CPU write burst in the middle
        push(8'h43);
        cyc();
        wcyc.delete();
        push(CH_FF);
        repeat (1000) cyc();
        cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'h55;
        repeat (5) begin
            #1;
            chk("cpu_pass_we",   32'(ram_we),    32'd1);
            chk("cpu_pass_re",   32'(ram_re),    32'd0);
            chk("cpu_pass_addr", 32'(ram_addr),  32'h123);
            chk("cpu_pass_data", 32'(ram_wdata), 32'h55);
            cyc();
        end
        cpu_we = 1'b0;
        drain(3000);
        chk("clr_cursor", 32'(cursor), 32'd0);
        chk("clr_nwr",    32'(wcyc.size()), 32'd2400);
        chk("clr_sb",     32'(expq.size()), 32'd0);
        if (wcyc.size() == 2400) begin
            chk("clr_span",     32'(wcyc[2399] - wcyc[0] + 1), 32'd2405);
            chk("clr_busy_end", 32'(cyc_no), 32'(wcyc[2399] + 1));
        end

        // CPU read holds off a printable byte at the head
        cpu_re = 1'b1; cpu_addr = 12'd7;
        push(8'h5A);
        repeat (3) begin
            #1;
            chk("hold_we",     32'(ram_we),   32'd0);
            chk("hold_re",     32'(ram_re),   32'd1);
            chk("hold_addr",   32'(ram_addr), 32'd7);
            chk("hold_cursor", 32'(cursor),   32'd0);
            chk("hold_busy",   32'(busy),     32'd1);
            cyc();
        end
        wcyc.delete();
        r = cyc_no;
        cpu_re = 1'b0;
        cyc();
        #1;
        chk("z_nwr",    32'(wcyc.size()), 32'd1);
        if (wcyc.size() == 1) chk("z_cyc", 32'(wcyc[0]), 32'(r));
        chk("z_cursor", 32'(cursor), 32'd1);

        // fill the FIFO while the engine is stalled
        cpu_we = 1'b1; cpu_addr = 12'd0; cpu_wdata = 8'd0;
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("full_ready", 32'(con_ready), 32'(i < 8));
            con_valid = 1'b1;
            con_data  = 8'h30 + 8'(i);
            if (i < 8) model_byte(con_data);
            cyc();
        end
        con_valid = 1'b0;
        #1;
        chk("full_ready_end", 32'(con_ready), 32'd0);
        cpu_we = 1'b0;
        wcyc.delete();
        drain(50);
        chk("full_nwr",    32'(wcyc.size()), 32'd8);
        chk("full_sb",     32'(expq.size()), 32'd0);
        chk("full_cursor", 32'(cursor),      32'd9);

        // backspace behaviour
        push(CH_CR);
        push(CH_BS);
        drain(20);
        chk("bs_at0", 32'(cursor), 32'd0);
        push(8'h51);
        push(CH_BS);
        drain(20);
        chk("bs_back", 32'(cursor), 32'(mcur));
        push(CH_LF);
        push(CH_BS);
        drain(20);
        chk("bs_prev_row", 32'(cursor), 32'd79);

        // reset in the middle of a clear
        push(CH_FF);
        repeat (100) cyc();
        reset = 1'b1;
        expq.delete();
        mcur = 0;
        cyc();
        reset = 1'b0;
        #1;
        chk("rstclr_cursor", 32'(cursor),    32'd0);
        chk("rstclr_busy",   32'(busy),      32'd0);
        chk("rstclr_ready",  32'(con_ready), 32'd1);
        wcyc.delete();
        repeat (20) cyc();
        chk("rstclr_nwr", 32'(wcyc.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
